// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - signal bundle between two requesters, the arbiter and memory
interface bus_arbiter_if;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_lock, m1_lock;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_err, m1_err;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_wstrb, m1_wstrb, m0_lock, m1_lock, mem_ready, mem_rdata,
    output m0_ready, m1_ready, m0_rdata, m1_rdata, m0_err, m1_err,
           mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  // Requester and memory view.
  modport master (
    output m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_wstrb, m1_wstrb, m0_lock, m1_lock, mem_ready, mem_rdata,
    input  m0_ready, m1_ready, m0_rdata, m1_rdata, m0_err, m1_err,
           mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin two-port memory arbiter with lock and stall timeout
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       resetn,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, next_state;
  logic        last_grant, next_last_grant;
  logic [15:0] cnt, next_cnt;

  logic        busy1;
  logic        sel_valid, sel_lock;
  logic        done, tmo;
  logic [31:0] rsp_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
      cnt        <= next_cnt;
    end
  end

  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    next_cnt        = cnt;
    busy1           = (state == BUSY1);
    sel_valid       = 1'b0;
    sel_lock        = 1'b0;
    done            = 1'b0;
    tmo             = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wstrb   = '0;
    bus.m0_ready    = 1'b0;
    bus.m1_ready    = 1'b0;
    bus.m0_err      = 1'b0;
    bus.m1_err      = 1'b0;
    bus.m0_rdata    = '0;
    bus.m1_rdata    = '0;

    case (state)
      IDLE: begin
        // On a tie, the port that did not finish last wins.
        if (bus.m0_valid && (!bus.m1_valid || last_grant)) begin
          next_state = BUSY0;
          next_cnt   = '0;
        end else if (bus.m1_valid) begin
          next_state = BUSY1;
          next_cnt   = '0;
        end
      end
      BUSY0, BUSY1: begin
        sel_valid     = busy1 ? bus.m1_valid : bus.m0_valid;
        sel_lock      = busy1 ? bus.m1_lock  : bus.m0_lock;
        bus.mem_valid = sel_valid;
        bus.mem_addr  = busy1 ? bus.m1_addr  : bus.m0_addr;
        bus.mem_wdata = busy1 ? bus.m1_wdata : bus.m0_wdata;
        bus.mem_wstrb = busy1 ? bus.m1_wstrb : bus.m0_wstrb;
        if (sel_valid && bus.mem_ready) begin
          done     = 1'b1;
          next_cnt = '0;
          if (!sel_lock) begin
            next_state      = IDLE;
            next_last_grant = busy1;
          end
        end else if (sel_valid && (cnt == TO_LAST)) begin
          // A stalled memory ends the transfer with an error, even under lock.
          done            = 1'b1;
          tmo             = 1'b1;
          next_cnt        = '0;
          next_state      = IDLE;
          next_last_grant = busy1;
        end else if (sel_valid) begin
          next_cnt = cnt + 16'd1;
        end else if (!sel_lock) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    rsp_data = tmo ? 32'hFFFF_FFFF : bus.mem_rdata;
    if (state == BUSY0) begin
      bus.m0_ready = done;
      bus.m0_err   = tmo;
      bus.m0_rdata = done ? rsp_data : '0;
    end
    if (state == BUSY1) begin
      bus.m1_ready = done;
      bus.m1_err   = tmo;
      bus.m1_rdata = done ? rsp_data : '0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter against a transaction model
module tb_bus_arbiter;
  localparam int T = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic        pv [2];
  logic [31:0] pa [2];
  logic [31:0] pw [2];
  logic [3:0]  ps [2];
  logic        pl [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.m0_valid = pv[0]; bus.m0_addr = pa[0]; bus.m0_wdata = pw[0];
    bus.m0_wstrb = ps[0]; bus.m0_lock = pl[0];
    bus.m1_valid = pv[1]; bus.m1_addr = pa[1]; bus.m1_wdata = pw[1];
    bus.m1_wstrb = ps[1]; bus.m1_lock = pl[1];
  endtask

  task automatic clr();
    for (int p = 0; p < 2; p++) begin
      pv[p] = 1'b0; pa[p] = '0; pw[p] = '0; ps[p] = '0; pl[p] = 1'b0;
    end
    drive();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  function automatic logic v_of(int p);
    return (p == 1) ? bus.m1_valid : bus.m0_valid;
  endfunction
  function automatic logic l_of(int p);
    return (p == 1) ? bus.m1_lock : bus.m0_lock;
  endfunction
  function automatic logic [31:0] a_of(int p);
    return (p == 1) ? bus.m1_addr : bus.m0_addr;
  endfunction
  function automatic logic [31:0] w_of(int p);
    return (p == 1) ? bus.m1_wdata : bus.m0_wdata;
  endfunction
  function automatic logic [3:0] s_of(int p);
    return (p == 1) ? bus.m1_wstrb : bus.m0_wstrb;
  endfunction

  // Transaction-level reference: who owns the bus, who finished last,
  // and how many stalled cycles the current transfer has seen.
  int owner = -1;
  int lg    = 1;
  int stall = 0;

  always @(negedge clk) begin : model
    logic [1:0]  er, ee;
    logic        emv;
    logic [31:0] ea, ew, erd;
    logic [3:0]  es;
    int          n;
    er = '0; ee = '0; emv = 1'b0; ea = '0; ew = '0; es = '0; erd = '0;
    if (!resetn) begin
      owner = -1; lg = 1; stall = 0;
    end else if (owner < 0) begin
      if (v_of(0) && v_of(1)) owner = 1 - lg;
      else if (v_of(0))       owner = 0;
      else if (v_of(1))       owner = 1;
      stall = 0;
    end else begin
      n   = owner;
      emv = v_of(n);
      ea  = a_of(n);
      ew  = w_of(n);
      es  = s_of(n);
      if (v_of(n) && bus.mem_ready) begin
        er[n] = 1'b1;
        erd   = bus.mem_rdata;
        stall = 0;
        if (!l_of(n)) begin
          lg = n; owner = -1;
        end
      end else if (v_of(n) && (stall + 1 == T)) begin
        er[n] = 1'b1; ee[n] = 1'b1; erd = 32'hFFFF_FFFF;
        lg = n; owner = -1; stall = 0;
      end else if (v_of(n)) begin
        stall++;
      end else if (!l_of(n)) begin
        owner = -1;
      end
    end
    chk("mem_valid", {31'b0, bus.mem_valid}, {31'b0, emv});
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_wdata", bus.mem_wdata, ew);
    chk("mem_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, es});
    chk("m0_ready", {31'b0, bus.m0_ready}, {31'b0, er[0]});
    chk("m1_ready", {31'b0, bus.m1_ready}, {31'b0, er[1]});
    chk("m0_err", {31'b0, bus.m0_err}, {31'b0, ee[0]});
    chk("m1_err", {31'b0, bus.m1_err}, {31'b0, ee[1]});
    if (er[0]) chk("m0_rdata", bus.m0_rdata, erd);
    if (er[1]) chk("m1_rdata", bus.m1_rdata, erd);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end, expected completion");
    $fatal(1, "watchdog");
  end

  logic [1:0] rr_exp [8];
  logic       busy [2];
  logic       seen [2];

  initial begin
    rr_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    // Reset with live requests and memory responding: everything must stay quiet.
    resetn = 1'b0;
    clr();
    pv[0] = 1'b1; pa[0] = 32'h0000_0100;
    pv[1] = 1'b1; pa[1] = 32'h0000_0200;
    drive();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hA5A5_A5A5;
    neg();
    chk("rst_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
    chk("rst_ready", {30'b0, bus.m1_ready, bus.m0_ready}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);

    // Round robin, one-cycle memory, both ports requesting continuously.
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      neg();
      chk("rr_ready", {30'b0, bus.m1_ready, bus.m0_ready}, {30'b0, rr_exp[i]});
      tick();
    end
    clr();

    // Single read, memory answers two cycles after mem_valid.
    pv[0] = 1'b1; pa[0] = 32'h0000_1000; ps[0] = 4'h0;
    drive();
    neg();
    chk("rd_idle_valid", {31'b0, bus.mem_valid}, 32'd0);
    tick(); neg();
    chk("rd_grant_valid", {31'b0, bus.mem_valid}, 32'd1);
    chk("rd_grant_addr", bus.mem_addr, 32'h0000_1000);
    tick(); neg();
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    neg();
    chk("rd_ready", {31'b0, bus.m0_ready}, 32'd1);
    chk("rd_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    chk("rd_err", {31'b0, bus.m0_err}, 32'd0);
    tick();
    clr();
    neg();
    chk("rd_back_idle", {31'b0, bus.mem_valid}, 32'd0);

    // Locked read then write from port 1 while port 0 waits.
    tick();
    pv[0] = 1'b1; pa[0] = 32'h0000_3000;
    pv[1] = 1'b1; pa[1] = 32'h0000_2000; ps[1] = 4'h0; pl[1] = 1'b1;
    drive();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_2222;
    neg();
    chk("lk_idle_valid", {31'b0, bus.mem_valid}, 32'd0);
    tick(); neg();
    chk("lk_rd_ready", {30'b0, bus.m1_ready, bus.m0_ready}, 32'd2);
    chk("lk_rd_addr", bus.mem_addr, 32'h0000_2000);
    tick();
    ps[1] = 4'hF; pw[1] = 32'h1234_5678; pl[1] = 1'b0;
    drive();
    neg();
    chk("lk_wr_ready", {30'b0, bus.m1_ready, bus.m0_ready}, 32'd2);
    chk("lk_wr_wdata", bus.mem_wdata, 32'h1234_5678);
    tick();
    pv[1] = 1'b0; drive();
    neg();
    chk("lk_gap_valid", {31'b0, bus.mem_valid}, 32'd0);
    tick(); neg();
    chk("lk_m0_ready", {30'b0, bus.m1_ready, bus.m0_ready}, 32'd1);
    chk("lk_m0_addr", bus.mem_addr, 32'h0000_3000);
    tick();
    clr();

    // Timeout: memory never answers.
    pv[0] = 1'b1; pa[0] = 32'h0000_4000;
    drive();
    neg();
    for (int c = 1; c <= 8; c++) begin
      tick(); neg();
      chk("to_ready", {31'b0, bus.m0_ready}, (c == 8) ? 32'd1 : 32'd0);
      chk("to_err", {31'b0, bus.m0_err}, (c == 8) ? 32'd1 : 32'd0);
      if (c == 8) chk("to_rdata", bus.m0_rdata, 32'hFFFF_FFFF);
    end
    tick(); neg();
    chk("to_back_idle", {31'b0, bus.mem_valid}, 32'd0);
    tick();
    clr();
    tick();

    // Reset in the middle of a port 1 transfer.
    pv[1] = 1'b1; pa[1] = 32'h0000_5000;
    drive();
    neg();
    tick(); neg();
    chk("rm_busy_valid", {31'b0, bus.mem_valid}, 32'd1);
    tick();
    resetn = 1'b0;
    pv[0] = 1'b1; pa[0] = 32'h0000_6000;
    drive();
    neg();
    chk("rm_async_valid", {31'b0, bus.mem_valid}, 32'd0);
    chk("rm_no_m1_ready", {31'b0, bus.m1_ready}, 32'd0);
    tick();
    resetn = 1'b1;
    neg();
    tick(); neg();
    chk("rm_regrant_addr", bus.mem_addr, 32'h0000_6000);
    tick();
    bus.mem_ready = 1'b1;
    neg();
    tick();
    clr();

    // Port 0 withdraws its request; pending port 1 request follows.
    pv[0] = 1'b1; pa[0] = 32'h0000_7000;
    drive();
    neg();
    tick();
    pv[1] = 1'b1; pa[1] = 32'h0000_8000; drive();
    neg();
    chk("dr_m0_addr", bus.mem_addr, 32'h0000_7000);
    tick();
    pv[0] = 1'b0; drive();
    neg();
    chk("dr_drop_valid", {31'b0, bus.mem_valid}, 32'd0);
    chk("dr_no_ready", {31'b0, bus.m0_ready}, 32'd0);
    tick(); neg();
    tick(); neg();
    chk("dr_m1_addr", bus.mem_addr, 32'h0000_8000);
    tick();
    bus.mem_ready = 1'b1;
    neg();
    chk("dr_m1_ready", {31'b0, bus.m1_ready}, 32'd1);
    tick();
    clr();

    // Randomized traffic: requesters hold requests until ready, random memory latency.
    busy[0] = 1'b0; busy[1] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      neg();
      seen[0] = bus.m0_ready;
      seen[1] = bus.m1_ready;
      tick();
      if ($urandom_range(0, 299) == 0) begin
        resetn = 1'b0;
        busy[0] = 1'b0; busy[1] = 1'b0;
        pv[0] = 1'b0; pv[1] = 1'b0;
      end else begin
        resetn = 1'b1;
        for (int p = 0; p < 2; p++) begin
          if (seen[p]) busy[p] = 1'b0;
          if (!busy[p]) begin
            if ($urandom_range(0, 2) == 0) begin
              busy[p] = 1'b1;
              pv[p]   = 1'b1;
              pa[p]   = $urandom;
              pw[p]   = $urandom;
              ps[p]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
              pl[p]   = ($urandom_range(0, 3) == 0);
            end else begin
              pv[p] = 1'b0;
              pl[p] = pl[p] && ($urandom_range(0, 1) == 0);
            end
          end
        end
      end
      drive();
      bus.mem_ready = ($urandom_range(0, 9) < 3);
      bus.mem_rdata = $urandom;
    end

    resetn = 1'b1;
    clr();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
